// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module mips_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] dw,
    input  logic [ADDR_W-1:0] rw,
    input  logic              rf_wr,
    output logic [DATA_W-1:0] crs,
    output logic [DATA_W-1:0] crt
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_ok_s;

    assign wr_ok_s = rf_wr && (rw != ADDR_W'(0));

    // Register array: async clear, write on rising edge; address 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[rw] <= dw;
        end else begin
            regs_r[rw] <= regs_r[rw];
        end
    end

    // Read port A; outputs are forced to zero while reset is asserted
    always_comb begin
        crs = '0;
        if (!rst_n) begin
            crs = '0;
        end else if (rs == ADDR_W'(0)) begin
            crs = '0;
`ifdef RF_BYPASS_EN
        end else if (wr_ok_s && (rs == rw)) begin
            crs = dw;
`endif
        end else begin
            crs = regs_r[rs];
        end
    end

    // Read port B, same rules as port A
    always_comb begin
        crt = '0;
        if (!rst_n) begin
            crt = '0;
        end else if (rt == ADDR_W'(0)) begin
            crt = '0;
`ifdef RF_BYPASS_EN
        end else if (wr_ok_s && (rt == rw)) begin
            crt = dw;
`endif
        end else begin
            crt = regs_r[rt];
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: expected operands are queued when stimulus is applied
// and compared once the combinational outputs have settled.
module tb_mips_register_file;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] dw;
    logic [4:0]  rw;
    logic        rf_wr;
    logic [31:0] crs;
    logic [31:0] crt;

    typedef struct {
        string       tag;
        logic [31:0] e_crs;
        logic [31:0] e_crt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    int          checks = 0;
    int          errors = 0;

    mips_register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (rs),
        .rt    (rt),
        .dw    (dw),
        .rw    (rw),
        .rf_wr (rf_wr),
        .crs   (crs),
        .crt   (crt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] e_crs, input logic [31:0] e_crt);
        exp_t e;
        e.tag   = tag;
        e.e_crs = e_crs;
        e.e_crt = e_crt;
        sb_q.push_back(e);
    endtask

    // Let the combinational read settle, then drain the scoreboard against the live outputs
    task automatic sb_check();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "_crs"}, crs, e.e_crs);
            check_val({e.tag, "_crt"}, crt, e.e_crt);
        end
    endtask

    // One rising edge; the model records the write the array should have taken
    task automatic tick();
        @(posedge clk);
        if (rst_n && rf_wr && rw != 5'd0) mdl[rw] = dw;
        #2;
    endtask

    function automatic logic [31:0] mdl_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    task automatic drive(input logic wr, input logic [4:0] w, input logic [31:0] d,
                         input logic [4:0] a, input logic [4:0] b);
        rf_wr = wr; rw = w; dw = d; rs = a; rt = b;
    endtask

    initial begin
        logic [4:0]  ra, rb;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd20, 5'd31);
        #3;
        sb_push("in_reset", 32'd0, 32'd0);
        sb_check();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int a = 0; a < 32; a++) begin
            rs = 5'(a); rt = 5'(31 - a);
            sb_push("reset_sweep", 32'd0, 32'd0);
            sb_check();
        end

        // First write to r20, with a pre-edge collision look
        drive(1'b1, 5'd20, 32'h0000_00F5, 5'd20, 5'd0);
        sb_push("w20_pre", BYPASS ? 32'h0000_00F5 : 32'd0, 32'd0);
        sb_check();
        tick();
        sb_push("w20_post", 32'h0000_00F5, 32'd0);
        sb_check();
        rf_wr = 1'b0;
        tick();
        sb_push("w20_hold", 32'h0000_00F5, 32'd0);
        sb_check();

        drive(1'b0, 5'd20, 32'h0000_00F5, 5'd0, 5'd20);
        sb_push("cross", 32'd0, 32'h0000_00F5);
        sb_check();
        dw = 32'h1234_5678;
        tick();
        sb_push("no_wr", 32'd0, 32'h0000_00F5);
        sb_check();

        drive(1'b1, 5'd17, 32'h0000_0003, 5'd31, 5'd2);
        sb_push("w17_pre", 32'd0, 32'd0);
        sb_check();
        tick();
        sb_push("w17_post", 32'd0, 32'd0);
        sb_check();
        drive(1'b0, 5'd17, 32'h0000_0003, 5'd20, 5'd17);
        sb_push("rd_20_17", 32'h0000_00F5, 32'h0000_0003);
        sb_check();

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        sb_push("r0_pre", 32'd0, 32'd0);
        sb_check();
        tick();
        rf_wr = 1'b0;
        sb_push("r0_post", 32'd0, 32'd0);
        sb_check();

        drive(1'b1, 5'd5, 32'h0000_00A5, 5'd5, 5'd5);
        sb_push("coll_pre", BYPASS ? 32'h0000_00A5 : 32'd0, BYPASS ? 32'h0000_00A5 : 32'd0);
        sb_check();
        tick();
        rf_wr = 1'b0;
        sb_push("coll_post", 32'h0000_00A5, 32'h0000_00A5);
        sb_check();

        // Random writes followed by reads checked against the model
        for (int n = 0; n < 40; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'd0, 5'd0);
            tick();
            ra = 5'($urandom_range(0, 31));
            rb = (n % 4 == 0) ? ra : 5'($urandom_range(0, 31));
            drive(1'b0, rw, dw, ra, rb);
            sb_push("rand", mdl_rd(ra), mdl_rd(rb));
            sb_check();
        end

        // Asynchronous reset between edges, with a write attempted while held
        drive(1'b1, 5'd20, 32'h0000_00F5, 5'd20, 5'd17);
        tick();
        rf_wr = 1'b0;
        sb_push("pre_arst", 32'h0000_00F5, mdl_rd(5'd17));
        sb_check();
        @(negedge clk);
        rst_n = 1'b0;
        sb_push("arst_now", 32'd0, 32'd0);
        sb_check();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        drive(1'b1, 5'd20, 32'h0000_0077, 5'd20, 5'd20);
        tick();
        @(negedge clk);
        rf_wr = 1'b0;
        rst_n = 1'b1;
        sb_push("arst_no_wr", 32'd0, 32'd0);
        sb_check();
        rs = 5'd17; rt = 5'd5;
        sb_push("arst_cleared", 32'd0, 32'd0);
        sb_check();

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
